// File: rtl/lvdc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lvdc_pkg
// Description : Shared constants, phase encodings and FSM state type for the
//               delay-line controller.
// Revision    : 1.0 - initial release
// ============================================================================
package lvdc_pkg;

    localparam int c_WORD_BITS_DEF = 26;
    localparam int c_BITT_W        = 5;

    // Phase encodings; strobe vector bit n corresponds to phase n
    localparam logic [1:0] c_PH_W = 2'd0;
    localparam logic [1:0] c_PH_X = 2'd1;
    localparam logic [1:0] c_PH_Y = 2'd2;
    localparam logic [1:0] c_PH_Z = 2'd3;

    // Position of the line-select bit inside SEL (0 = DL44, 1 = DL31)
    localparam int c_SEL_LINE_BIT = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALIGN = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } dl_state_t;

    function automatic logic [3:0] phase_onehot(input logic [1:0] ph);
        logic [3:0] v;
        case (ph)
            c_PH_W:  v = 4'b0001;
            c_PH_X:  v = 4'b0010;
            c_PH_Y:  v = 4'b0100;
            default: v = 4'b1000;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dl_phase_timer.sv
`default_nettype none
// ============================================================================
// Module      : dl_phase_timer
// Description : Four-phase (W/X/Y/Z) sequencer and bit-time counter with
//               registered one-hot strobes and word-sync pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module dl_phase_timer
    import lvdc_pkg::*;
#(
    parameter int WORD_BITS = c_WORD_BITS_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_en,
    output logic [1:0]          o_phase,
    output logic [c_BITT_W-1:0] o_bitt,
    output logic [3:0]          o_strb,
    output logic                o_wsync
);

    localparam logic [c_BITT_W-1:0] c_BITT_LAST = c_BITT_W'(WORD_BITS - 1);

    logic [1:0]          r_phase;
    logic [1:0]          w_phase_nxt;
    logic [c_BITT_W-1:0] r_bitt;
    logic [c_BITT_W-1:0] w_bitt_nxt;
    logic [3:0]          r_strb;
    logic                r_wsync;

    // Next phase/bit-time: advance one phase per enabled clock, bump bit-time on Z->W
    always_comb begin
        w_phase_nxt = r_phase;
        w_bitt_nxt  = r_bitt;
        if (i_en) begin
            w_phase_nxt = r_phase + 2'd1;
            if (r_phase == c_PH_Z) begin
                w_bitt_nxt = (r_bitt == c_BITT_LAST) ? '0 : r_bitt + 1'b1;
            end
        end
    end

    // Counter state plus strobes registered from the upcoming phase (dark while disabled)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= c_PH_W;
            r_bitt  <= '0;
            r_strb  <= 4'b0000;
            r_wsync <= 1'b0;
        end else begin
            r_phase <= w_phase_nxt;
            r_bitt  <= w_bitt_nxt;
            r_strb  <= i_en ? phase_onehot(w_phase_nxt) : 4'b0000;
            r_wsync <= i_en && (w_phase_nxt == c_PH_W) && (w_bitt_nxt == '0);
        end
    end

    assign o_phase = r_phase;
    assign o_bitt  = r_bitt;
    assign o_strb  = r_strb;
    assign o_wsync = r_wsync;

endmodule
`default_nettype wire

// File: rtl/delay_line_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : delay_line_ctrl
// Description : Two-port round-robin access controller for the 44- and 31-
//               recirculating delay lines; serial read/write in a phase slot.
// Revision    : 1.0 - initial release
// ============================================================================
module delay_line_ctrl
    import lvdc_pkg::*;
#(
    parameter int WORD_BITS = c_WORD_BITS_DEF,
    parameter int NPORT     = 2
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    input  logic                 EN,
    input  logic                 DL44SA,
    input  logic                 DL31SA,
    output logic                 DL44,
    output logic                 DL31,
    output logic                 W,
    output logic                 X,
    output logic                 Y,
    output logic                 Z,
    output logic                 WN,
    output logic                 XN,
    output logic                 YN,
    output logic                 ZN,
    output logic [4:0]           BITT,
    output logic                 WSYNC,
    input  logic                 REQA,
    input  logic                 REQB,
    input  logic                 WRA,
    input  logic                 WRB,
    input  logic [2:0]           SELA,
    input  logic [2:0]           SELB,
    input  logic [WORD_BITS-1:0] WDA,
    input  logic [WORD_BITS-1:0] WDB,
    output logic                 GNTA,
    output logic                 GNTB,
    output logic                 DONEA,
    output logic                 DONEB,
    output logic [WORD_BITS-1:0] RDATA,
    output logic                 BUSY
);

    localparam logic [c_BITT_W-1:0] c_BITT_LAST = c_BITT_W'(WORD_BITS - 1);

    logic [1:0]          w_phase;
    logic [c_BITT_W-1:0] w_bitt;
    logic [3:0]          w_strb;
    logic                w_wsync;

    dl_state_t           r_state;
    dl_state_t           w_state_nxt;
    logic                r_wr;
    logic [2:0]          r_sel;
    logic [WORD_BITS-1:0] r_wd;
    logic [WORD_BITS-1:0] r_rdata;
    logic                r_owner_b;
    logic                r_last_b;
    logic [NPORT-1:0]    r_gnt;
    logic [NPORT-1:0]    r_done;

    logic w_grant_a;
    logic w_grant_b;
    logic w_slot;
    logic w_act;
    logic w_line31;
    logic w_wr_act;
    logic w_rd_act;
    logic w_line_sa;
    logic w_bit_last;

    dl_phase_timer #(
        .WORD_BITS (WORD_BITS)
    ) u_timer (
        .clk     (CLK),
        .rst_n   (RSTN),
        .i_en    (EN),
        .o_phase (w_phase),
        .o_bitt  (w_bitt),
        .o_strb  (w_strb),
        .o_wsync (w_wsync)
    );

    // A slot is the enabled cycle whose phase matches the latched selector;
    // the first active slot must fall on bit-time 0 so bit k lands at bit-time k.
    assign w_slot     = EN && (w_phase == r_sel[1:0]);
    assign w_act      = w_slot && (((r_state == ST_ALIGN) && (w_bitt == '0)) ||
                                   (r_state == ST_SHIFT));
    assign w_line31   = r_sel[c_SEL_LINE_BIT];
    assign w_wr_act   = w_act && r_wr;
    assign w_rd_act   = w_act && !r_wr;
    assign w_line_sa  = w_line31 ? DL31SA : DL44SA;
    assign w_bit_last = (w_bitt == c_BITT_LAST);

    // Arbitration and sequencing: round-robin grant in IDLE, wait for bit 0, shift, report
    always_comb begin
        w_state_nxt = r_state;
        w_grant_a   = 1'b0;
        w_grant_b   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (REQA && (!REQB || r_last_b)) begin
                    w_grant_a = 1'b1;
                end else if (REQB) begin
                    w_grant_b = 1'b1;
                end
                if (REQA || REQB) begin
                    w_state_nxt = ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                if (w_act) begin
                    w_state_nxt = w_bit_last ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_act && w_bit_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Request latch, round-robin pointer, grant/done pulses and read capture
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_wr      <= 1'b0;
            r_sel     <= 3'b000;
            r_wd      <= '0;
            r_owner_b <= 1'b0;
            r_last_b  <= 1'b1;
            r_gnt     <= '0;
            r_done    <= '0;
            r_rdata   <= '0;
        end else begin
            r_gnt <= {w_grant_b, w_grant_a};
            if (w_grant_a || w_grant_b) begin
                r_owner_b <= w_grant_b;
                r_last_b  <= w_grant_b;
                r_wr      <= w_grant_b ? WRB  : WRA;
                r_sel     <= w_grant_b ? SELB : SELA;
                r_wd      <= w_grant_b ? WDB  : WDA;
            end
            if ((w_state_nxt == ST_DONE) && (r_state != ST_DONE)) begin
                r_done <= r_owner_b ? 2'b10 : 2'b01;
            end else begin
                r_done <= '0;
            end
            if (w_rd_act) begin
                r_rdata[w_bitt] <= w_line_sa;
            end
        end
    end

    // Lines recirculate their sense-amp output except during this block's write slot
    assign DL44 = (w_wr_act && !w_line31) ? r_wd[w_bitt] : DL44SA;
    assign DL31 = (w_wr_act &&  w_line31) ? r_wd[w_bitt] : DL31SA;

    assign W     = w_strb[0];
    assign X     = w_strb[1];
    assign Y     = w_strb[2];
    assign Z     = w_strb[3];
    assign WN    = ~w_strb[0];
    assign XN    = ~w_strb[1];
    assign YN    = ~w_strb[2];
    assign ZN    = ~w_strb[3];
    assign BITT  = w_bitt;
    assign WSYNC = w_wsync;
    assign GNTA  = r_gnt[0];
    assign GNTB  = r_gnt[1];
    assign DONEA = r_done[0];
    assign DONEB = r_done[1];
    assign RDATA = r_rdata;
    assign BUSY  = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_delay_line_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_delay_line_ctrl
// Description : Scoreboard bench for delay_line_ctrl: timing chain, writes,
//               reads, round-robin ties, EN pause and mid-operation reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_delay_line_ctrl;

    localparam int WB = 26;

    logic          CLK, RSTN, EN, DL44SA, DL31SA;
    logic          DL44, DL31, W, X, Y, Z, WN, XN, YN, ZN, WSYNC;
    logic [4:0]    BITT;
    logic          REQA, REQB, WRA, WRB;
    logic [2:0]    SELA, SELB;
    logic [WB-1:0] WDA, WDB, RDATA;
    logic          GNTA, GNTB, DONEA, DONEB, BUSY;

    typedef struct {
        logic [1:0]    port;
        bit            rd;
        logic [WB-1:0] rdata;
    } done_t;

    logic [1:0] exp_gnt[$];
    done_t      exp_done[$];
    logic [1:0] eg;
    done_t      ed;

    int n_checks = 0;
    int n_err    = 0;

    // Bench reference timing model and the data the modelled 31-line returns
    logic [1:0]    m_phase;
    logic [4:0]    m_bitt;
    logic          m_en_q;
    logic [WB-1:0] pat31;

    delay_line_ctrl #(.WORD_BITS(WB), .NPORT(2)) dut (
        .CLK(CLK), .RSTN(RSTN), .EN(EN), .DL44SA(DL44SA), .DL31SA(DL31SA),
        .DL44(DL44), .DL31(DL31), .W(W), .X(X), .Y(Y), .Z(Z),
        .WN(WN), .XN(XN), .YN(YN), .ZN(ZN), .BITT(BITT), .WSYNC(WSYNC),
        .REQA(REQA), .REQB(REQB), .WRA(WRA), .WRB(WRB), .SELA(SELA), .SELB(SELB),
        .WDA(WDA), .WDB(WDB), .GNTA(GNTA), .GNTB(GNTB), .DONEA(DONEA), .DONEB(DONEB),
        .RDATA(RDATA), .BUSY(BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] onehot(input logic [1:0] ph);
        logic [3:0] v;
        v = 4'b0001 << ph;
        return v;
    endfunction

    // Reference phase/bit-time model
    always @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            m_phase <= 2'd0;
            m_bitt  <= 5'd0;
            m_en_q  <= 1'b0;
        end else begin
            m_en_q <= EN;
            if (EN) begin
                m_phase <= m_phase + 2'd1;
                if (m_phase == 2'd3) m_bitt <= (m_bitt == 5'd25) ? 5'd0 : m_bitt + 5'd1;
            end
        end
    end

    // Sense-amp stimulus: 44-line noise; 31-line returns pat31 in X slots
    always @(negedge CLK) begin
        DL44SA = 1'($urandom);
        DL31SA = (m_phase == 2'd1) ? pat31[m_bitt] : 1'($urandom);
    end

    // Scoreboard monitor
    always @(negedge CLK) begin
        #1;
        if (GNTA || GNTB) begin
            if (exp_gnt.size() == 0) begin
                chk("gnt_unexpected", {30'd0, GNTB, GNTA}, 32'd0);
            end else begin
                eg = exp_gnt.pop_front();
                chk("gnt_port", {30'd0, GNTB, GNTA}, {30'd0, eg});
            end
        end
        if (DONEA || DONEB) begin
            if (exp_done.size() == 0) begin
                chk("done_unexpected", {30'd0, DONEB, DONEA}, 32'd0);
            end else begin
                ed = exp_done.pop_front();
                chk("done_port", {30'd0, DONEB, DONEA}, {30'd0, ed.port});
                if (ed.rd) chk("rdata", {6'd0, RDATA}, {6'd0, ed.rdata});
            end
        end
    end

    task automatic chk_reset(input string tag);
        chk({tag, "_strobes"}, {28'd0, Z, Y, X, W}, 32'd0);
        chk({tag, "_compl"}, {28'd0, ZN, YN, XN, WN}, 32'hF);
        chk({tag, "_bitt"}, {27'd0, BITT}, 32'd0);
        chk({tag, "_wsync"}, {31'd0, WSYNC}, 32'd0);
        chk({tag, "_busy"}, {31'd0, BUSY}, 32'd0);
        chk({tag, "_rdata"}, {6'd0, RDATA}, 32'd0);
        chk({tag, "_gnt_done"}, {28'd0, GNTA, GNTB, DONEA, DONEB}, 32'd0);
        chk({tag, "_recirc"}, {30'd0, DL44, DL31}, {30'd0, DL44SA, DL31SA});
    endtask

    task automatic run_op(input bit pb, input bit wr, input logic [2:0] sel,
                          input logic [WB-1:0] wd, input logic [WB-1:0] exp_rd,
                          input int pause_bit, input int rst_bit);
        logic [WB-1:0] got;
        logic          line;
        logic [1:0]    pph;
        int            ncap, bad, lat, nd, nb;
        bit            granted, started, capdone, done, paused, aborted;
        got = '0; ncap = 0; bad = 0; lat = 0; nd = 0; nb = 0;
        granted = 0; started = 0; capdone = 0; done = 0; paused = 0; aborted = 0;
        pph = sel[1:0] + 2'd2;
        exp_gnt.push_back(pb ? 2'b10 : 2'b01);
        exp_done.push_back('{port: (pb ? 2'b10 : 2'b01), rd: !wr, rdata: exp_rd});
        if (pb) begin REQB = 1; WRB = wr; SELB = sel; WDB = wd; end
        else    begin REQA = 1; WRA = wr; SELA = sel; WDA = wd; end
        for (int n = 0; n < 400 && !done && !aborted; n++) begin
            @(negedge CLK); #2;
            if (!granted && (GNTA || GNTB)) begin
                granted = 1;
                REQA = 0; REQB = 0;
            end
            if (granted) lat++;
            if (DONEA || DONEB) done = 1;
            line = sel[2] ? DL31 : DL44;
            if (BUSY && !capdone && EN && (m_phase == sel[1:0]) && (started || m_bitt == 5'd0)) begin
                started = 1;
                if (m_bitt == 5'd25) capdone = 1;
                if (wr) begin
                    got[m_bitt] = line;
                    ncap++;
                    if (sel[2]) begin if (DL44 !== DL44SA) bad++; end
                    else        begin if (DL31 !== DL31SA) bad++; end
                end else begin
                    if (DL44 !== DL44SA) bad++;
                    if (DL31 !== DL31SA) bad++;
                end
            end else begin
                if (DL44 !== DL44SA) bad++;
                if (DL31 !== DL31SA) bad++;
            end
            if (pause_bit >= 0 && !paused && started && m_bitt == 5'(pause_bit) && m_phase == pph) begin
                EN = 0;
                for (int p = 0; p < 10; p++) begin
                    @(negedge CLK); #2;
                    chk("pause_strobes", {28'd0, Z, Y, X, W}, 32'd0);
                    chk("pause_bitt", {27'd0, BITT}, 32'(pause_bit));
                    if (DL44 !== DL44SA) bad++;
                    if (DL31 !== DL31SA) bad++;
                end
                EN = 1;
                paused = 1;
            end
            if (rst_bit >= 0 && started && m_bitt == 5'(rst_bit)) begin
                RSTN = 0;
                #1;
                chk_reset("midop_rst");
                exp_gnt.delete();
                exp_done.delete();
                aborted = 1;
                @(negedge CLK);
                RSTN = 1;
            end
        end
        if (rst_bit >= 0) begin
            chk("abort_reached", {31'd0, aborted}, 32'd1);
            for (int n = 0; n < 300; n++) begin
                @(negedge CLK); #2;
                if (DONEA || DONEB) nd++;
                if (BUSY) nb++;
                if (DL44 !== DL44SA) bad++;
                if (DL31 !== DL31SA) bad++;
            end
            chk("no_done_after_rst", nd, 0);
            chk("busy_after_rst", nb, 0);
        end else begin
            chk("op_done_seen", {31'd0, done}, 32'd1);
            if (wr) begin
                chk("write_data", {6'd0, got}, {6'd0, wd});
                chk("write_bits", ncap, WB);
            end
            if (pause_bit < 0) chk("latency_bound", {31'd0, (lat <= 8 * WB + 1)}, 32'd1);
            @(negedge CLK); #2;
            chk("busy_after_done", {31'd0, BUSY}, 32'd0);
        end
        chk("recirculation", bad, 0);
    endtask

    task automatic tie(input bit exp_b);
        bit granted, idle;
        granted = 0; idle = 0;
        exp_gnt.push_back(exp_b ? 2'b10 : 2'b01);
        exp_done.push_back('{port: (exp_b ? 2'b10 : 2'b01), rd: 1'b1, rdata: pat31});
        REQA = 1; REQB = 1; WRA = 0; WRB = 0; SELA = 3'b101; SELB = 3'b101;
        for (int n = 0; n < 10 && !granted; n++) begin
            @(negedge CLK); #2;
            if (GNTA || GNTB) granted = 1;
        end
        REQA = 0; REQB = 0;
        chk("tie_granted", {31'd0, granted}, 32'd1);
        for (int n = 0; n < 300 && !idle; n++) begin
            @(negedge CLK); #2;
            if (!BUSY) idle = 1;
        end
        chk("tie_completed", {31'd0, idle}, 32'd1);
    endtask

    initial begin
        int nws;
        logic [3:0] es;
        pat31 = 26'h1555555;
        RSTN = 0; EN = 0; DL44SA = 0; DL31SA = 0;
        REQA = 0; REQB = 0; WRA = 0; WRB = 0; SELA = 3'b000; SELB = 3'b000;
        WDA = '0; WDB = '0;
        repeat (3) @(negedge CLK);
        #2;
        chk_reset("reset");

        // Free-running timing chain for two full words
        EN = 1; RSTN = 1;
        nws = 0;
        for (int i = 0; i < 210; i++) begin
            @(negedge CLK); #2;
            es = m_en_q ? onehot(m_phase) : 4'b0000;
            chk("bitt", {27'd0, BITT}, {27'd0, m_bitt});
            chk("strobes", {28'd0, Z, Y, X, W}, {28'd0, es});
            chk("complements", {28'd0, ZN, YN, XN, WN}, {28'd0, ~es});
            chk("wsync", {31'd0, WSYNC}, {31'd0, (m_en_q && m_phase == 2'd0 && m_bitt == 5'd0)});
            if (WSYNC) nws++;
        end
        chk("wsync_count", nws, 2);

        // Write port A into DL44 Y slots
        run_op(1'b0, 1'b1, 3'b010, 26'h2AAAAAA, '0, -1, -1);
        // Write with a 10-cycle EN pause in the middle of the shift
        run_op(1'b0, 1'b1, 3'b000, 26'h3C0FF0A, '0, 10, -1);
        // Reset in the middle of a shift
        run_op(1'b0, 1'b1, 3'b011, 26'h0F0F0F0, '0, -1, 5);

        // Round-robin ties (reads of DL31 X slots): A, then B, then A
        tie(1'b0);
        tie(1'b1);
        tie(1'b0);

        // Read from port B alone
        run_op(1'b1, 1'b0, 3'b101, '0, 26'h1555555, -1, -1);

        repeat (4) @(negedge CLK);
        chk("scoreboard_empty", exp_gnt.size() + exp_done.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/delay_line_ctrl.md
DELAY_LINE_CTRL -- requirements
Module: delay_line_ctrl

Interface
REQ-001 Parameter WORD_BITS, default 26: serial word length in bit-times.
REQ-002 Parameter NPORT, fixed 2: number of requester ports, A and B.
REQ-003 Ports: CLK in 1, the single clock; RSTN in 1, asynchronous active-low reset.
REQ-004 EN in 1: run enable; when low, timing and shifting freeze.
REQ-005 DL44SA, DL31SA in 1 each: sense-amp outputs of the 44- and 31-line.
REQ-006 DL44, DL31 out 1 each: write-gate data to the lines.
REQ-007 W, X, Y, Z out 1 each: registered one-hot phase strobes; WN, XN, YN, ZN out 1 each: complements.
REQ-008 BITT out 5: current bit-time, 0..WORD_BITS-1; WSYNC out 1: pulse at bit-time 0, phase W.
REQ-009 REQA/REQB in 1: request; WRA/WRB in 1: 1=write, 0=read; SELA/SELB in 3: bit2 selects line (0=DL44, 1=DL31), bits1:0 select phase slot W..Z; WDA/WDB in WORD_BITS: write data.
REQ-010 GNTA/GNTB out 1: grant pulse; DONEA/DONEB out 1: completion pulse; RDATA out WORD_BITS: read result; BUSY out 1.

Function
REQ-011 The phase counter SHALL advance W->X->Y->Z->W once per CLK while EN=1 and SHALL hold while EN=0.
REQ-012 BITT SHALL increment on the Z->W transition and wrap from WORD_BITS-1 to 0; WSYNC SHALL be high for the W cycle of bit-time 0.
REQ-013 Strobes SHALL be 0 while EN=0; exactly one of W/X/Y/Z SHALL be 1 while EN=1.
REQ-014 The slot of a request SHALL be the cycle where phase equals SEL[1:0] on the line SEL[2].
REQ-015 When no write shifts on a line, DL44 SHALL equal DL44SA and DL31 SHALL equal DL31SA (recirculation).
REQ-016 States: IDLE, ALIGN, SHIFT, DONE.
REQ-017 IDLE: on any REQ, latch WR, SEL, and WD of the winner, pulse its GNT for 1 cycle, and enter ALIGN.
REQ-018 Arbitration SHALL be round-robin: on a tie, grant the port not granted last; after reset, A wins the first tie.
REQ-019 ALIGN: enter SHIFT at the first slot cycle with BITT=0, which is bit 0.
REQ-020 SHIFT: at each slot cycle k, a write SHALL drive the selected line output = WD[k] and a read SHALL capture line SA into RDATA[k]; non-selected lines keep recirculating.
REQ-021 After slot k=WORD_BITS-1, the block SHALL enter DONE, pulse the granted port's DONE for 1 cycle, then return to IDLE.
REQ-022 RDATA SHALL update only on reads and SHALL hold otherwise.
REQ-023 A REQ dropped after GNT SHALL NOT abort the operation.
REQ-024 A REQ asserted while BUSY SHALL wait and is not queued beyond the level held.
REQ-025 BUSY SHALL be 1 in ALIGN, SHIFT, and DONE.
REQ-026 EN=0 mid-SHIFT SHALL pause the operation without corruption and resume on EN=1.
REQ-027 Worst-case latency from GNT to DONE SHALL be 8*WORD_BITS+1 enabled cycles.

Reset
REQ-028 RSTN low SHALL asynchronously force: phase=W internal, BITT=0, strobes 0, complements 1, WSYNC 0, state IDLE, GNT/DONE 0, BUSY 0, RDATA 0, round-robin pointer to favour A, DL44/DL31 recirculating.
REQ-029 Reset mid-operation SHALL abort it with no DONE and no further line writes.

Structure
REQ-030 Package lvdc_pkg SHALL hold WORD_BITS default, phase encodings W=0..Z=3, the SEL line-bit position, and the FSM state enum.
REQ-031 Phase and bit-time generation SHALL be one sub-module, dl_phase_timer; the arbiter and FSM live in delay_line_ctrl.

Verification
REQ-032 EN=1 from reset for 4*26 cycles -> strobes cycle W,X,Y,Z; BITT 0..25 then 0; WSYNC once every 104 cycles.
REQ-033 REQA WRA=1 SELA=3'b010 WDA=26'h2AAAAAA -> GNTA next cycle; DL44 carries pattern LSB-first in Y slots from BITT=0; DONEA at 1 pulse; other slots equal DL44SA.
REQ-034 REQA and REQB same cycle twice -> grants A then B, then on the next tie A; DONE pulses match the granted port.
REQ-035 Model DL31SA returning 26'h155_5555 in X slots; REQB read SELB=3'b101 -> RDATA=26'h1555555 at DONEB.
REQ-036 EN low 10 cycles mid-SHIFT -> resumes with correct data; RSTN low mid-SHIFT -> IDLE, BUSY 0, no DONE, outputs at reset values.
